// File: rtl/fft_src_pkg.sv
// -----------------------------------------------------------------------------
// fft_src_pkg
// Shared definitions for the FFT frame source: FSM state encoding, the layout
// of the 24-bit configuration word sent to the FFT core, and the FFT/IFFT
// mode constants. Also provides pack_cfg(), which assembles that word.
// -----------------------------------------------------------------------------
package fft_src_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CFG    = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Configuration word layout
  localparam int CFG_W    = 24;
  localparam int LEN_LSB  = 0;
  localparam int LEN_MSB  = 15;
  localparam int MODE_BIT = 16;

  localparam logic MODE_FFT  = 1'b0;
  localparam logic MODE_IFFT = 1'b1;

  // Length field carries frame_len-1; bits above MODE_BIT are reserved zero.
  function automatic logic [CFG_W-1:0] pack_cfg(input logic [15:0] len_m1,
                                                 input logic        mode);
    logic [CFG_W-1:0] w;
    w                  = '0;
    w[LEN_MSB:LEN_LSB] = len_m1;
    w[MODE_BIT]        = mode;
    return w;
  endfunction

endpackage

// File: rtl/fft_src_fifo.sv
// -----------------------------------------------------------------------------
// fft_src_fifo
// Synchronous first-word-fall-through FIFO. The head entry is presented on
// rdata whenever empty is low, so a consumer sees data with no read latency.
// Push while full and pop while empty are ignored. Simultaneous push and pop
// leave the occupancy unchanged.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write wdata when not full
//   wdata      write data
//   pop        discard head entry when not empty
//   rdata      head entry (valid while empty is low)
//   full       no free entries
//   empty      no stored entries
// -----------------------------------------------------------------------------
module fft_src_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fft_frame_src.sv
// -----------------------------------------------------------------------------
// fft_frame_src
// Input-side initiator for the burst FFT/IFFT core. A free-running complex
// sample stream is buffered in a small FIFO (which fills in every state). On a
// valid start the block sends one config word on the cfg handshake, then
// streams exactly frame_len samples on s_axi with last on the final one, and
// pulses done.
//
// Optional feature (macro FRAME_SRC_CONT_EN): when defined, cont = 1 in the
// DONE state starts the next frame immediately with the latched length and
// mode. When undefined, cont is ignored and DONE always returns to IDLE.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, frame_len,          frame request; length/mode latched on an
//   frame_mode                 accepted start in IDLE
//   cont                       continuous-frame request (optional feature)
//   src_valid/src_data/        producer sample handshake, data = {im, re}
//   src_ready
//   cfg_valid/cfg_data/        config word toward the core:
//   cfg_ready                  [15:0] len-1, [16] mode, [23:17] zero
//   s_axi_valid/last/data/     sample stream toward the core
//   s_axi_ready
//   busy                       not IDLE
//   done                       one-cycle pulse after the last sample
//   len_err                    one-cycle pulse on a rejected start
// -----------------------------------------------------------------------------
module fft_frame_src
  import fft_src_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic                    frame_mode,
  input  logic                    cont,
  input  logic                    src_valid,
  input  logic [2*DATA_WIDTH-1:0] src_data,
  output logic                    src_ready,
  output logic                    cfg_valid,
  output logic [CFG_W-1:0]        cfg_data,
  input  logic                    cfg_ready,
  output logic                    s_axi_valid,
  output logic                    s_axi_last,
  output logic [2*DATA_WIDTH-1:0] s_axi_data,
  input  logic                    s_axi_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    len_err
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [LEN_WIDTH:0] MIN_LEN = (LEN_WIDTH+1)'(2);
  localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH+1)'(2**(ADDR_WIDTH+1));

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 mode_q, mode_d;
  logic                 len_err_q, len_err_d;

  logic [LEN_WIDTH-1:0]    len_m1;
  logic [CNT_W-1:0]        last_idx;
  logic                    fifo_full, fifo_empty;
  logic [2*DATA_WIDTH-1:0] fifo_head;
  logic                    beat_acc;
  logic                    at_last;

  // Accept only powers of two from 2 up to the core's maximum frame length.
  function automatic logic len_ok(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH:0] ext;
    ext = {1'b0, len};
    return (ext >= MIN_LEN) && (ext <= MAX_LEN) &&
           ((len & (len - 1'b1)) == '0);
  endfunction

  fft_src_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (src_valid & src_ready),
    .wdata (src_data),
    .pop   (beat_acc),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign len_m1   = len_q - 1'b1;
  assign last_idx = CNT_W'(len_m1);
  assign at_last  = (cnt_q == last_idx);
  assign beat_acc = s_axi_valid & s_axi_ready;

  // Outputs. Data buses are forced to zero when not valid so that nothing
  // stale (e.g. uninitialised FIFO storage) is visible after reset.
  assign src_ready   = ~fifo_full;
  assign cfg_valid   = (state_q == ST_CFG);
  assign cfg_data    = cfg_valid ? pack_cfg(16'(len_m1), mode_q) : '0;
  assign s_axi_valid = (state_q == ST_STREAM) & ~fifo_empty;
  assign s_axi_last  = s_axi_valid & at_last;
  assign s_axi_data  = s_axi_valid ? fifo_head : '0;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign len_err     = len_err_q;

`ifndef FRAME_SRC_CONT_EN
  logic unused_cont;
  assign unused_cont = cont;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    len_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok(frame_len)) begin
            len_d   = frame_len;
            mode_d  = frame_mode;
            state_d = ST_CFG;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      ST_CFG: begin
        if (cfg_ready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (beat_acc) begin
          if (at_last) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
`ifdef FRAME_SRC_CONT_EN
        state_d = cont ? ST_CFG : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  // Latched frame parameters; only observed outside IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    len_q  <= len_d;
    mode_q <= mode_d;
  end

endmodule

// File: tb/tb_fft_frame_src.sv
module tb_fft_frame_src;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] frame_len;
  logic        frame_mode;
  logic        cont;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        cfg_valid;
  logic [23:0] cfg_data;
  logic        cfg_ready;
  logic        s_axi_valid;
  logic        s_axi_last;
  logic [31:0] s_axi_data;
  logic        s_axi_ready;
  logic        busy;
  logic        done;
  logic        len_err;

  always #5 clk = ~clk;

  fft_frame_src dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_len   (frame_len),
    .frame_mode  (frame_mode),
    .cont        (cont),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .s_axi_valid (s_axi_valid),
    .s_axi_last  (s_axi_last),
    .s_axi_data  (s_axi_data),
    .s_axi_ready (s_axi_ready),
    .busy        (busy),
    .done        (done),
    .len_err     (len_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [$];
  logic [31:0] next_val = 32'h0001_0000;

  typedef struct {
    logic [15:0] len;
    logic        mode;
    logic        exp_err;
    logic [23:0] exp_cfg;
  } len_vec_t;

  len_vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Producer: offers the next sequential sample with probability vpct and
  // records it in the model when the FIFO will accept it on the next edge.
  task automatic drive_src(input int vpct);
    if ($urandom_range(99) < vpct) begin
      src_valid = 1'b1;
      src_data  = next_val;
      if (src_ready) begin
        model.push_back(next_val);
        next_val++;
      end
    end else begin
      src_valid = 1'b0;
      src_data  = '0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_src_ready"},   src_ready,   1);
    chk({tag, "_cfg_valid"},   cfg_valid,   0);
    chk({tag, "_cfg_data"},    cfg_data,    0);
    chk({tag, "_s_axi_valid"}, s_axi_valid, 0);
    chk({tag, "_s_axi_last"},  s_axi_last,  0);
    chk({tag, "_s_axi_data"},  s_axi_data,  0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_done"},        done,        0);
    chk({tag, "_len_err"},     len_err,     0);
  endtask

  task automatic run_frame(input int len, input logic mode, input bit do_start,
                           input int vpct, input int rpct, input int cfg_delay,
                           input bit exp_cont, input int abort_beat);
    logic [23:0] exp_cfg;
    logic [31:0] held_data;
    logic [31:0] exp_d;
    logic        held_last;
    int          beat;
    int          budget;
    bit          stall;
    exp_cfg = {7'd0, mode, 16'(len - 1)};
    if (do_start) begin
      frame_len  = 16'(len);
      frame_mode = mode;
      start      = 1'b1;
      drive_src(vpct);
      step();
      start = 1'b0;
    end
    for (int i = 0; i <= cfg_delay; i++) begin
      chk("cfg_valid", cfg_valid, 1);
      chk("cfg_data", cfg_data, exp_cfg);
      chk("s_axi_valid_in_cfg", s_axi_valid, 0);
      cfg_ready = (i == cfg_delay);
      drive_src(vpct);
      step();
    end
    cfg_ready = 1'b0;
    chk("cfg_valid_drop", cfg_valid, 0);
    if (model.size() > 0) chk("first_valid_latency", s_axi_valid, 1);
    beat   = 0;
    budget = 0;
    stall  = 0;
    while (beat < len && budget < 20000 && beat != abort_beat) begin
      if (stall) begin
        chk("hold_valid", s_axi_valid, 1);
        chk("hold_data", s_axi_data, held_data);
        chk("hold_last", s_axi_last, held_last);
      end
      chk("last_flag", s_axi_last, (s_axi_valid && beat == len - 1));
      s_axi_ready = ($urandom_range(99) < rpct);
      if (s_axi_valid && s_axi_ready) begin
        n_cmp++;
        if (model.size() == 0) begin
          n_fail++;
          $display("FAIL sample_extra: got 0x%0h, required no sample (t=%0t)", s_axi_data, $time);
        end else begin
          exp_d = model.pop_front();
          if (s_axi_data !== exp_d) begin
            n_fail++;
            $display("FAIL sample_data: got 0x%0h, required 0x%0h beat %0d (t=%0t)",
                     s_axi_data, exp_d, beat, $time);
          end
        end
        beat++;
        stall = 0;
      end else begin
        stall     = s_axi_valid;
        held_data = s_axi_data;
        held_last = s_axi_last;
      end
      drive_src(vpct);
      step();
      budget++;
    end
    s_axi_ready = 1'b0;
    if (beat == abort_beat) return;
    if (beat < len) chk("stream_timeout_beats", beat, len);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    chk("no_valid_in_done", s_axi_valid, 0);
    drive_src(vpct);
    step();
    chk("done_single_cycle", done, 0);
    if (exp_cont) begin
      chk("cont_cfg_valid", cfg_valid, 1);
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_cfg_valid", cfg_valid, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    frame_len   = '0;
    frame_mode  = 1'b0;
    cont        = 1'b0;
    src_valid   = 1'b0;
    src_data    = '0;
    cfg_ready   = 1'b0;
    s_axi_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    model.delete();
    chk_reset_outputs("reset");

    vecs[0] = '{16'd0,    1'b0, 1'b1, 24'h000000};
    vecs[1] = '{16'd1,    1'b0, 1'b1, 24'h000000};
    vecs[2] = '{16'd12,   1'b0, 1'b1, 24'h000000};
    vecs[3] = '{16'd2048, 1'b0, 1'b1, 24'h000000};
    vecs[4] = '{16'd1025, 1'b1, 1'b1, 24'h000000};
    vecs[5] = '{16'd3,    1'b0, 1'b1, 24'h000000};
    vecs[6] = '{16'd2,    1'b0, 1'b0, 24'h000001};
    vecs[7] = '{16'd16,   1'b1, 1'b0, 24'h01000F};
    vecs[8] = '{16'd1024, 1'b1, 1'b0, 24'h0103FF};
    vecs[9] = '{16'd512,  1'b0, 1'b0, 24'h0001FF};

    for (int v = 0; v < 10; v++) begin
      frame_len  = vecs[v].len;
      frame_mode = vecs[v].mode;
      start      = 1'b1;
      step();
      start = 1'b0;
      chk("vec_len_err", len_err, vecs[v].exp_err);
      chk("vec_busy", busy, !vecs[v].exp_err);
      chk("vec_cfg_valid", cfg_valid, !vecs[v].exp_err);
      chk("vec_cfg_data", cfg_data, vecs[v].exp_cfg);
      step();
      chk("vec_len_err_pulse", len_err, 0);
      chk("vec_cfg_valid_hold", cfg_valid, !vecs[v].exp_err);
      chk("vec_cfg_data_hold", cfg_data, vecs[v].exp_cfg);
      if (!vecs[v].exp_err) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        model.delete();
      end
    end

    // Prefill while idle until the FIFO is full
    for (int i = 0; i < 16; i++) begin
      drive_src(100);
      step();
    end
    src_valid = 1'b0;
    chk("prefill_full", src_ready, 0);
    chk("prefill_idle_no_valid", s_axi_valid, 0);
    chk("prefill_idle_busy", busy, 0);

    run_frame(16, 1'b0, 1'b1, 100, 100, 0, 1'b0, -1);
    run_frame(1024, 1'b1, 1'b1, 100, 100, 5, 1'b0, -1);
    run_frame(64, 1'b0, 1'b1, 70, 50, 0, 1'b0, -1);

    // Reset in the middle of a 32-sample frame
    run_frame(32, 1'b0, 1'b1, 100, 100, 0, 1'b0, 7);
    rst         = 1'b1;
    src_valid   = 1'b0;
    s_axi_ready = 1'b0;
    step();
    rst = 1'b0;
    model.delete();
    chk_reset_outputs("midreset");
    step();
    chk("midreset_no_done", done, 0);
    run_frame(32, 1'b0, 1'b1, 100, 100, 0, 1'b0, -1);

`ifdef FRAME_SRC_CONT_EN
    cont = 1'b1;
    run_frame(8, 1'b0, 1'b1, 100, 100, 0, 1'b1, -1);
    run_frame(8, 1'b0, 1'b0, 100, 100, 0, 1'b1, -1);
    cont = 1'b0;
    run_frame(8, 1'b0, 1'b0, 100, 100, 0, 1'b0, -1);
`else
    cont = 1'b1;
    run_frame(8, 1'b0, 1'b1, 100, 100, 0, 1'b0, -1);
    cont = 1'b0;
`endif

    src_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
